// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the DIV control sequencer and the seq_divider core.
// The sequencer is the master: it drives start and the operands, and it reads back the status and result fields.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [2*WIDTH-1:0]   z_out;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, z_out
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, z_out
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider that produces the Z result {remainder, quotient} for DIV.
// Optional macro DIV_FAST_ZERO_EN finishes a zero-divisor request in one edge through the ZERO state.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         clr,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

`ifdef DIV_FAST_ZERO_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_ZERO} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
`endif

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic               r_signQ;
    logic               r_signR;
    logic [WIDTH-1:0]   r_dividendCap;
    logic [WIDTH-1:0]   r_divMag;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_p;
    logic               r_busy;
    logic               r_done;
    logic               r_divByZero;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic [WIDTH-1:0]   w_dividendMag;
    logic [WIDTH-1:0]   w_divisorMag;
    logic               w_divisorZero;
    logic [WIDTH:0]     w_pShift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_qFix;
    logic [WIDTH-1:0]   w_rFix;

    // 0x80000000 negates to itself, which is already the correct unsigned magnitude
    assign w_dividendMag = bus.dividend[WIDTH-1] ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
    assign w_divisorMag  = bus.divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - bus.divisor)  : bus.divisor;
    assign w_divisorZero = (bus.divisor == {WIDTH{1'b0}});

    // The shifted partial remainder needs WIDTH+1 bits; when it fits, the difference is below the divisor
    assign w_pShift = {r_p, r_a[WIDTH-1]};
    assign w_fits   = (w_pShift >= {1'b0, r_divMag});
    assign w_diff   = w_pShift[WIDTH-1:0] - r_divMag;

    assign w_qFix = r_signQ ? ({WIDTH{1'b0}} - r_a) : r_a;
    assign w_rFix = r_signR ? ({WIDTH{1'b0}} - r_p) : r_p;

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_divByZero;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.z_out       = {r_remainder, r_quotient};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_signQ       <= 1'b0;
            r_signR       <= 1'b0;
            r_dividendCap <= '0;
            r_divMag      <= '0;
            r_a           <= '0;
            r_p           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_divByZero   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_signQ       <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_signR       <= bus.dividend[WIDTH-1];
                        r_dividendCap <= bus.dividend;
                        r_a           <= w_dividendMag;
                        r_divMag      <= w_divisorMag;
                        r_p           <= '0;
                        r_count       <= '0;
                        r_busy        <= 1'b1;
                        r_divByZero   <= 1'b0;
`ifdef DIV_FAST_ZERO_EN
                        r_state       <= w_divisorZero ? S_ZERO : S_CALC;
`else
                        r_state       <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_p     <= w_fits ? w_diff : w_pShift[WIDTH-1:0];
                    r_a     <= {r_a[WIDTH-2:0], w_fits};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor runs the loop harmlessly; its result is overridden here
                    if (r_divMag == {WIDTH{1'b0}}) begin
                        r_quotient  <= {WIDTH{1'b1}};
                        r_remainder <= r_dividendCap;
                        r_divByZero <= 1'b1;
                    end else begin
                        r_quotient  <= w_qFix;
                        r_remainder <= w_rFix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
`ifdef DIV_FAST_ZERO_EN
                S_ZERO: begin
                    r_quotient  <= {WIDTH{1'b1}};
                    r_remainder <= r_dividendCap;
                    r_divByZero <= 1'b1;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Keeps the divisor-zero decode referenced when the fast path is compiled out
    logic w_unusedZero;
    assign w_unusedZero = w_divisorZero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed divisions push expected results, and a negedge monitor checks each done pulse.
// Result values, latency and the reset/ignored-start behaviour are all compared against hand-computed constants.
module tb_seq_divider;
    logic clk;
    logic clr;
    int   cycle;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          startCycle;
        int          lat;
    } exp_t;

    exp_t sbQ[$];

    seq_divider_if #(.WIDTH(32)) ifc ();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (clr && ifc.done) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending division");
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("quotient",    {32'h0, ifc.quotient},    {32'h0, e.q});
                checkOutput("remainder",   {32'h0, ifc.remainder},   {32'h0, e.r});
                checkOutput("z_out",       ifc.z_out,                {e.r, e.q});
                checkOutput("div_by_zero", {63'h0, ifc.div_by_zero}, {63'h0, e.dbz});
                checkOutput("busy_at_done", {63'h0, ifc.busy},       64'h0);
                checkOutput("latency",     64'(cycle - e.startCycle), 64'(e.lat));
            end
        end
    end

    // Called just after a negedge; start is sampled at the following posedge (E0)
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs,
                                 input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        ifc.dividend = dvd;
        ifc.divisor  = dvs;
        ifc.start    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start    = 1'b0;
        ifc.dividend = 32'hDEADBEEF;
        ifc.divisor  = 32'h12345678;
        e.q = q;
        e.r = r;
        e.dbz = dbz;
        e.startCycle = cycle;
`ifdef DIV_FAST_ZERO_EN
        e.lat = (dvs == 32'h0) ? 1 : 33;
`else
        e.lat = 33;
`endif
        sbQ.push_back(e);
        checkOutput("busy_after_start", {63'h0, ifc.busy}, 64'h1);
        checkOutput("dbz_cleared_at_start", {63'h0, ifc.div_by_zero}, 64'h0);
    endtask

    // Returns just after the negedge on which the monitor consumed the last expectation
    task automatic waitResult();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got %0d pending results expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        cycle = 0;
        total = 0;
        bad = 0;
        clr = 1'b0;
        ifc.start = 1'b0;
        ifc.dividend = 32'h0;
        ifc.divisor = 32'h0;
        #12;
        checkOutput("reset_busy", {63'h0, ifc.busy}, 64'h0);
        checkOutput("reset_done", {63'h0, ifc.done}, 64'h0);
        checkOutput("reset_dbz",  {63'h0, ifc.div_by_zero}, 64'h0);
        checkOutput("reset_z",    ifc.z_out, 64'h0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        #1;

        applyStimulus(32'h00000012, 32'h00000014, 32'h00000000, 32'h00000012, 1'b0);
        checkOutput("done_low_after_start", {63'h0, ifc.done}, 64'h0);
        waitResult();
        applyStimulus(32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        checkOutput("done_single_pulse", {63'h0, ifc.done}, 64'h0);
        waitResult();

        // A start raised mid-run must neither restart nor queue a second division
        applyStimulus(32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
        repeat (5) @(negedge clk);
        ifc.dividend = 32'd9;
        ifc.divisor = 32'd3;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        waitResult();

        applyStimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        waitResult();
        applyStimulus(32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        waitResult();
        applyStimulus(32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 1'b1);
        waitResult();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("dbz_holds", {63'h0, ifc.div_by_zero}, 64'h1);

        // Reset in the middle of a run discards it
        applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        ifc.dividend = 32'd9;
        ifc.divisor = 32'd3;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        sbQ.delete();
        clr = 1'b0;
        #1;
        checkOutput("midrun_reset_busy", {63'h0, ifc.busy}, 64'h0);
        checkOutput("midrun_reset_done", {63'h0, ifc.done}, 64'h0);
        checkOutput("midrun_reset_q",    {32'h0, ifc.quotient}, 64'h0);
        checkOutput("midrun_reset_r",    {32'h0, ifc.remainder}, 64'h0);
        checkOutput("midrun_reset_dbz",  {63'h0, ifc.div_by_zero}, 64'h0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checkOutput("idle_after_reset_busy", {63'h0, ifc.busy}, 64'h0);
        applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        waitResult();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit divider that computes the Z result for the DIV instruction.
- The dividend is taken from the Y register and the divisor from the bus in the ALU step of the instruction.
- The 64-bit result is presented as {remainder, quotient}. The Z register loads it, so Zhigh holds the remainder and Zlow holds the quotient; Zlow then goes to LO and Zhigh to HI.
- The control sequencer waits on `done` before asserting Zin.

Parameters:
- WIDTH, 32, operand width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- clr  input  1  reset, asynchronous, active-low
- start  input  1  request a division; sampled only in IDLE
- dividend  input  WIDTH  signed dividend (Y register)
- divisor  input  WIDTH  signed divisor (bus)
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when the result registers update
- div_by_zero  output  1  set with done when divisor was 0; holds until next start
- quotient  output  WIDTH  registered signed quotient
- remainder  output  WIDTH  registered signed remainder
- z_out  output  2*WIDTH  {remainder, quotient}, wired straight to the Z register input

Behaviour:
- Reset (clr low, any time, including mid-operation):
  - state goes to IDLE.
  - busy, done, div_by_zero, quotient, remainder and the internal counter all go to 0.
  - An in-flight division is discarded and done never pulses for it.
- States: IDLE, CALC, FIX, plus ZERO when DIV_FAST_ZERO_EN is defined.
- IDLE:
  - On the rising edge with start=1 (edge E0), capture sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Load the unsigned magnitudes |dividend| and |divisor|, clear the partial remainder, set count=0, busy=1, div_by_zero=0, and go to CALC.
  - With start=0, hold everything. done drops to 0 on the edge after it was raised.
- CALC:
  - Restoring division, one quotient bit per edge, MSB first. Shift {P, A} left by 1, then trial-subtract the divisor magnitude from P.
  - If the difference is non-negative, P = difference and the quotient bit is 1. Otherwise P is kept and the bit is 0.
  - Use a WIDTH+1-bit subtractor, so a magnitude of 0x80000000 is handled.
  - count increments each edge. After WIDTH edges (E1..E32), go to FIX.
- FIX (edge E33):
  - quotient = sign_q ? −Qmag : Qmag.
  - remainder = sign_r ? −Rmag : Rmag.
  - Assert done=1 and busy=0, then return to IDLE.
  - Latency: done is high in the cycle after E33, i.e. 33 edges after start was sampled.
- Result rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend and satisfies |remainder| < |divisor|.
  - −2^31 / −1 gives quotient 0x80000000 and remainder 0 (wraps, no flag).
- Divide by zero (divisor == 0):
  - quotient = all ones, remainder = dividend unchanged, div_by_zero=1 alongside done.
  - Without DIV_FAST_ZERO_EN this takes the full 33-edge latency. FIX forces these values.
- start while busy is ignored and does not restart or queue.
- dividend and divisor may change after E0; the captured values are used.
- quotient, remainder and z_out hold their values until the next FIX/ZERO completion or a reset.
- start on the same edge that done falls is accepted normally. The back-to-back issue interval is 34 cycles.

Optional Feature:
- Macro DIV_FAST_ZERO_EN.
- Defined: at E0 a zero divisor sends IDLE to ZERO. At E1 the ZERO state writes quotient=all ones, remainder=dividend, div_by_zero=1, done=1, busy=0, and returns to IDLE. Latency is 1 edge.
- Undefined: the ZERO state does not exist. A zero divisor runs through CALC/FIX with the same final values and the standard 33-edge latency.

Test Plan:
- Case 1: dividend=0x00000012, divisor=0x00000014, start pulsed one cycle.
  - busy rises after E0 and done pulses one cycle after E33.
  - quotient=0x00000000, remainder=0x00000012, z_out=0x00000012_00000000.
- Case 2: dividend=−7 (0xFFFFFFF9), divisor=2.
  - quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
- Case 3: dividend=7, divisor=−2 (0xFFFFFFFE).
  - quotient=0xFFFFFFFD (−3), remainder=0x00000001.
- Case 4: dividend=0x80000000, divisor=0xFFFFFFFF.
  - quotient=0x80000000, remainder=0x00000000, div_by_zero=0.
- Case 5: dividend=0x64, divisor=0.
  - quotient=0xFFFFFFFF, remainder=0x00000064, div_by_zero=1.
  - done one edge after start with DIV_FAST_ZERO_EN, 33 edges after start without it.
- Case 6: start 100/7. Re-pulse start with 9/3 at edge E5, then pull clr low at edge E10 + 3 ns.
  - The E5 start is ignored.
  - At reset, busy, quotient and remainder go to 0 immediately, and done never pulses.
  - After release, a new 100/7 returns quotient 14, remainder 2.
